nios_system_nios2_qsys_0_cpu_oci_dct_packer: RTL and testbench

- Transmit side of the OCI direct-control-transfer (DCT) trace path.
- Collects 2-bit DCT records retired by the CPU into a 30-bit buffer of up to 15 entries, with a live 4-bit entry count.
- Emits completed frames (buffer + count) to the trace consumer through a one-deep valid/ready output slot.
- Sits between the CPU retire/trace-control logic and the OCI trace packer / test-bench monitor.

---
 rtl/nios_system_nios2_qsys_0_cpu_oci_pkg.sv | 22 ++
 rtl/nios_system_nios2_qsys_0_cpu_oci_frame_slot.sv | 81 ++++++++
 rtl/nios_system_nios2_qsys_0_cpu_oci_dct_packer.sv | 82 ++++++++
 tb/tb_nios_system_nios2_qsys_0_cpu_oci_dct_packer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_nios2_qsys_0_cpu_oci_pkg.sv
// Shared constants, DCT record encodings and frame type for the OCI DCT trace path.
package nios_system_nios2_qsys_0_cpu_oci_pkg;

    localparam int ENTRY_W     = 2;
    localparam int MAX_ENTRIES = 15;
    localparam int CNT_W       = 4;
    localparam int DCT_BUF_W   = ENTRY_W * MAX_ENTRIES;
    localparam int DROP_W      = 8;

    typedef enum logic [ENTRY_W-1:0] {
        DCT_NOT_TAKEN = 2'b00,
        DCT_TAKEN     = 2'b01,
        DCT_INDIRECT  = 2'b10,
        DCT_KIND      = 2'b11
    } dct_code_e;

    typedef struct packed {
        logic [DCT_BUF_W-1:0] buffer;
        logic [CNT_W-1:0]     count;
    } dct_frame_t;

endpackage

// File: rtl/nios_system_nios2_qsys_0_cpu_oci_frame_slot.sv
// One-deep valid/ready output slot; frames offered while the slot is full and not
// being consumed are dropped and counted.
module nios_system_nios2_qsys_0_cpu_oci_frame_slot
    import nios_system_nios2_qsys_0_cpu_oci_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_offer,
    input  dct_frame_t        i_frame,
    input  logic              i_ready,
    input  logic              i_ovf_clr,
    output logic              o_valid,
    output dct_frame_t        o_frame,
    output logic              o_overflow,
    output logic [DROP_W-1:0] o_dropped
);

    typedef enum logic {S_EMPTY, S_FULL} slot_state_e;

    slot_state_e       r_state;
    slot_state_e       w_state_nxt;
    logic              w_load;
    logic              w_drop;
    dct_frame_t        r_frame;
    logic              r_ovf;
    logic [DROP_W-1:0] r_drop;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (i_offer) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                // Consume and refill in the same cycle keeps the slot full without a bubble.
                if (i_ready) begin
                    w_load      = i_offer;
                    w_state_nxt = i_offer ? S_FULL : S_EMPTY;
                end else begin
                    w_drop = i_offer;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_EMPTY;
            r_frame <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) r_frame <= i_frame;
            // A drop coinciding with a clear restarts the count at one.
            if (w_drop) begin
                r_ovf  <= 1'b1;
                r_drop <= i_ovf_clr ? DROP_W'(1) : sat_inc(r_drop);
            end else if (i_ovf_clr) begin
                r_ovf  <= 1'b0;
                r_drop <= '0;
            end
        end
    end

    assign o_valid    = (r_state == S_FULL);
    assign o_frame    = r_frame;
    assign o_overflow = r_ovf;
    assign o_dropped  = r_drop;

endmodule

// File: rtl/nios_system_nios2_qsys_0_cpu_oci_dct_packer.sv
// Packs retired 2-bit DCT records LSB-first into frames of up to 15 entries and
// hands closed frames to a one-deep output slot.
module nios_system_nios2_qsys_0_cpu_oci_dct_packer
    import nios_system_nios2_qsys_0_cpu_oci_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trace_enable,
    input  logic                 dct_valid,
    input  logic [ENTRY_W-1:0]   dct_code,
    input  logic                 flush,
    input  logic                 frame_ready,
    input  logic                 overflow_clr,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0]     dct_count,
    output logic                 frame_valid,
    output logic [DCT_BUF_W-1:0] frame_buffer,
    output logic [CNT_W-1:0]     frame_count,
    output logic                 overflow,
    output logic [DROP_W-1:0]    dropped_frames
);

    logic [DCT_BUF_W-1:0] r_buf;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_en_q;

    logic                 w_accept;
    logic [DCT_BUF_W-1:0] w_rec;
    logic [DCT_BUF_W-1:0] w_buf_acc;
    logic [CNT_W-1:0]     w_cnt_acc;
    logic                 w_close;
    logic                 w_offer;
    dct_frame_t           w_frame_in;
    dct_frame_t           w_frame_out;

    assign w_accept  = dct_valid & trace_enable;
    assign w_rec     = DCT_BUF_W'(dct_code) << (ENTRY_W * int'(r_cnt));
    assign w_buf_acc = w_accept ? (r_buf | w_rec) : r_buf;
    assign w_cnt_acc = r_cnt + CNT_W'(w_accept);

    // Close is judged on the post-accept view so a record arriving with flush joins the closing frame.
    assign w_close = (w_cnt_acc == CNT_W'(MAX_ENTRIES)) | flush | (r_en_q & ~trace_enable);
    assign w_offer = w_close & (w_cnt_acc != '0);

    assign w_frame_in = '{buffer: w_buf_acc, count: w_cnt_acc};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf  <= '0;
            r_cnt  <= '0;
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= trace_enable;
            if (w_offer) begin
                r_buf <= '0;
                r_cnt <= '0;
            end else begin
                r_buf <= w_buf_acc;
                r_cnt <= w_cnt_acc;
            end
        end
    end

    nios_system_nios2_qsys_0_cpu_oci_frame_slot u_slot (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_offer    (w_offer),
        .i_frame    (w_frame_in),
        .i_ready    (frame_ready),
        .i_ovf_clr  (overflow_clr),
        .o_valid    (frame_valid),
        .o_frame    (w_frame_out),
        .o_overflow (overflow),
        .o_dropped  (dropped_frames)
    );

    assign dct_buffer   = r_buf;
    assign dct_count    = r_cnt;
    assign frame_buffer = w_frame_out.buffer;
    assign frame_count  = w_frame_out.count;

endmodule

// File: tb/tb_nios_system_nios2_qsys_0_cpu_oci_dct_packer.sv
// Bench for the DCT packer: behavioural model with a frame scoreboard, a vector table
// and hand-written sequences for backpressure, enable edges and reset.
module tb_nios_system_nios2_qsys_0_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset, trace_enable, dct_valid, flush, frame_ready, overflow_clr;
    logic [1:0]  dct_code;
    logic [29:0] dct_buffer, frame_buffer;
    logic [3:0]  dct_count, frame_count;
    logic        frame_valid, overflow;
    logic [7:0]  dropped_frames;

    always #5 clk = ~clk;

    nios_system_nios2_qsys_0_cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .trace_enable   (trace_enable),
        .dct_valid      (dct_valid),
        .dct_code       (dct_code),
        .flush          (flush),
        .frame_ready    (frame_ready),
        .overflow_clr   (overflow_clr),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .frame_valid    (frame_valid),
        .frame_buffer   (frame_buffer),
        .frame_count    (frame_count),
        .overflow       (overflow),
        .dropped_frames (dropped_frames)
    );

    typedef struct {
        logic [29:0] b;
        logic [3:0]  c;
    } frm_t;

    typedef struct {
        logic       v;
        logic [1:0] code;
        logic       f;
        logic       r;
        logic       en;
        logic       clr;
        logic [3:0] exp_cnt;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    frm_t        q[$];
    frm_t        fr;
    logic [29:0] mbuf;
    logic [3:0]  mcnt;
    logic        men_q, movf;
    logic [7:0]  mdrop;
    vec_t        tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mbuf = '0; mcnt = '0; men_q = 1'b0; movf = 1'b0; mdrop = '0;
        q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; trace_enable = 1'b0; dct_valid = 1'b0; dct_code = 2'b00;
        flush = 1'b0; frame_ready = 1'b0; overflow_clr = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_buf"},   32'(dct_buffer),     0);
        chk({tag, "_cnt"},   32'(dct_count),      0);
        chk({tag, "_fv"},    32'(frame_valid),    0);
        chk({tag, "_fbuf"},  32'(frame_buffer),   0);
        chk({tag, "_fcnt"},  32'(frame_count),    0);
        chk({tag, "_ovf"},   32'(overflow),       0);
        chk({tag, "_drop"},  32'(dropped_frames), 0);
    endtask

    // One clock: check outputs against the model, drive inputs, advance model and DUT.
    task automatic cyc(input logic v, input logic [1:0] code, input logic f,
                       input logic r, input logic en, input logic clr);
        logic        acc, close, offer, full_before;
        logic [3:0]  cnt_acc;
        logic [29:0] buf_acc;
        dct_valid = v; dct_code = code; flush = f; frame_ready = r;
        trace_enable = en; overflow_clr = clr;

        chk("dct_count",  32'(dct_count),  32'(mcnt));
        chk("dct_buffer", 32'(dct_buffer), 32'(mbuf));
        chk("frame_valid", 32'(frame_valid), 32'(q.size() != 0));
        chk("overflow",   32'(overflow),   32'(movf));
        chk("dropped",    32'(dropped_frames), 32'(mdrop));

        full_before = (q.size() != 0);
        if (full_before) begin
            chk("slot_buf", 32'(frame_buffer), 32'(q[0].b));
            chk("slot_cnt", 32'(frame_count),  32'(q[0].c));
            if (r) void'(q.pop_front());
        end

        acc     = v && en;
        cnt_acc = mcnt + 4'(acc);
        buf_acc = acc ? (mbuf | (30'(code) << (2 * int'(mcnt)))) : mbuf;
        close   = (cnt_acc == 4'd15) || f || (men_q && !en);
        offer   = close && (cnt_acc != 0);

        if (offer && full_before && !r) begin
            movf  = 1'b1;
            mdrop = clr ? 8'd1 : ((mdrop == 8'hFF) ? mdrop : mdrop + 8'd1);
        end else begin
            if (clr) begin movf = 1'b0; mdrop = '0; end
            if (offer) begin
                fr.b = buf_acc; fr.c = cnt_acc;
                q.push_back(fr);
            end
        end
        if (offer) begin mbuf = '0; mcnt = '0; end
        else begin mbuf = buf_acc; mcnt = cnt_acc; end
        men_q = en;

        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[1]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
        tbl[2]  = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3};
        tbl[3]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[5]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[6]  = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[7]  = '{1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
        tbl[8]  = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3};
        tbl[9]  = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4};
        tbl[10] = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};

        do_reset();
        chk_zero("reset");

        // Full frame, descending codes, auto close.
        for (int k = 0; k < 15; k++) cyc(1'b1, 2'(3 - (k % 4)), 1'b0, 1'b1, 1'b1, 1'b0);
        chk("auto_fv",   32'(frame_valid),  1);
        chk("auto_fbuf", 32'(frame_buffer), 32'h1B1B1B1B);
        chk("auto_fcnt", 32'(frame_count),  15);
        chk("auto_live", 32'(dct_count),    0);

        // Second frame held back, then consumed in the same cycle it auto closes.
        for (int k = 0; k < 14; k++) cyc(1'b1, 2'(k % 4), 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("b2b_fv",   32'(frame_valid),  1);
        chk("b2b_fbuf", 32'(frame_buffer), 32'h24E4E4E4);
        chk("b2b_fcnt", 32'(frame_count),  15);
        chk("b2b_ovf",  32'(overflow),     0);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);

        // Partial flush, empty flush, and record arriving together with flush.
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].v, tbl[i].code, tbl[i].f, tbl[i].r, tbl[i].en, tbl[i].clr);
            chk($sformatf("tbl%0d_cnt", i), 32'(dct_count), 32'(tbl[i].exp_cnt));
        end

        // Backpressure: first frame held, second dropped.
        cyc(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("bp_ovf",  32'(overflow),       1);
        chk("bp_drop", 32'(dropped_frames), 1);
        chk("bp_fbuf", 32'(frame_buffer),   32'h9);
        chk("bp_fcnt", 32'(frame_count),    2);
        chk("bp_live", 32'(dct_count),      0);
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_ovf",  32'(overflow),       0);
        chk("clr_drop", 32'(dropped_frames), 0);
        chk("clr_fv",   32'(frame_valid),    1);
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("drop_clr_ovf",  32'(overflow),       1);
        chk("drop_clr_drop", 32'(dropped_frames), 1);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);

        // Enable falling edge closes the partial frame; records are ignored while disabled.
        for (int k = 0; k < 7; k++) cyc(1'b1, 2'(k % 4), 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("en_fv",   32'(frame_valid), 1);
        chk("en_fcnt", 32'(frame_count), 7);
        chk("en_live", 32'(dct_count),   0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("dis_cnt", 32'(dct_count), 0);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a fill.
        for (int k = 0; k < 9; k++) cyc(1'b1, 2'(k % 4), 1'b0, 1'b1, 1'b1, 1'b0);
        chk("mid_cnt", 32'(dct_count), 9);
        do_reset();
        chk_zero("midrst");
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
